// File: rtl/fpu_pkg.sv
// Shared FPU format constants, status encoding and float layout.
// Imported by the FPU datapath and the float-to-int converter.
package fpu_pkg;

  localparam int EXP_W  = 6;
  localparam int MANT_W = 25;
  localparam int BIAS   = 31;

  localparam int ST_EXACT     = 0;
  localparam int ST_OVERFLOW  = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_INEXACT   = 3;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fpu_float_t;

  function automatic logic [3:0] st_bit(
    input int idx
  );
    st_bit = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/fpu_f2i_classify.sv
// Classifies a captured float: special results, or shift plan
// that aligns the significand to the integer binary point.
module fpu_f2i_classify
  import fpu_pkg::*;
(
  input  fpu_float_t  op,
  output logic        special,
  output logic [31:0] spec_result,
  output logic [3:0]  spec_status,
  output logic        shift_left,
  output logic [4:0]  shift_cnt
);

  localparam logic [EXP_W-1:0] E_ONE  = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] E_SAT  = EXP_W'(BIAS + 31);
  localparam logic [EXP_W-1:0] E_FLAT = EXP_W'(BIAS + MANT_W);

  logic [EXP_W-1:0] up;
  logic [EXP_W-1:0] dn;

  assign up = op.exp - E_FLAT;
  assign dn = E_FLAT - op.exp;

  // Pick special-case result or the alignment shift.
  always_comb begin
    special     = 1'b0;
    spec_result = '0;
    spec_status = '0;
    shift_left  = 1'b0;
    shift_cnt   = '0;
    unique case (1'b1)
      (op.exp == '0): begin
        special     = 1'b1;
        spec_status = (op.mant == '0) ?
                      st_bit(ST_EXACT) :
                      st_bit(ST_UNDERFLOW);
      end
      (op.exp != '0 && op.exp < E_ONE): begin
        special     = 1'b1;
        spec_status = st_bit(ST_UNDERFLOW);
      end
      (op.exp >= E_SAT): begin
        special = 1'b1;
        if (op.exp == E_SAT && op.sign &&
            op.mant == '0) begin
          spec_result = 32'h8000_0000;
          spec_status = st_bit(ST_EXACT);
        end else begin
          spec_result = op.sign ? 32'h8000_0000 :
                                  32'h7FFF_FFFF;
          spec_status = st_bit(ST_OVERFLOW);
        end
      end
      default: begin
        shift_left = (op.exp > E_FLAT);
        shift_cnt  = shift_left ? up[4:0] : dn[4:0];
      end
    endcase
  end

endmodule

// File: rtl/fpu_f2i.sv
// Iterative float-to-int converter, truncating toward zero.
// One alignment bit per cycle; start/busy/done handshake.
module fpu_f2i
  import fpu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_in,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_NEGATE,
    S_DONE
  } state_t;

  state_t      state;
  fpu_float_t  op_r;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        dir_left;
  logic        sticky;

  logic        special;
  logic [31:0] spec_result;
  logic [3:0]  spec_status;
  logic        shift_left;
  logic [4:0]  shift_cnt;

  fpu_f2i_classify u_classify (
    .op          (op_r),
    .special     (special),
    .spec_result (spec_result),
    .spec_status (spec_status),
    .shift_left  (shift_left),
    .shift_cnt   (shift_cnt)
  );

  // Conversion FSM with registered results and handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      op_r       <= '0;
      acc        <= '0;
      cnt        <= '0;
      dir_left   <= 1'b0;
      sticky     <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_r  <= op_in;
            busy  <= 1'b1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (special) begin
            data_out   <= spec_result;
            status_out <= spec_status;
            done       <= 1'b1;
            state      <= S_DONE;
          end else begin
            acc      <= {6'b0, 1'b1, op_r.mant};
            sticky   <= 1'b0;
            dir_left <= shift_left;
            cnt      <= shift_cnt;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (cnt != '0) begin
            cnt <= cnt - 5'd1;
            if (dir_left) begin
              acc <= acc << 1;
            end else begin
              acc    <= acc >> 1;
              sticky <= sticky | acc[0];
            end
          end else begin
            state <= S_NEGATE;
          end
        end
        S_NEGATE: begin
          data_out   <= op_r.sign ? -acc : acc;
          status_out <= sticky ? st_bit(ST_INEXACT) :
                                 st_bit(ST_EXACT);
          done       <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
